// File: rtl/irq_controller.sv
// Interrupt controller: per-source edge/level latching, masking and a single CPU request,
// with a four-register bus slave (PENDING, MASK, VECTOR, MODE).
module irq_controller #(
    parameter int N_SRC = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_i,
    input  logic             we_i,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    input  logic [N_SRC-1:0] irq_i,
    output logic             int_o
);

    localparam logic [1:0] ADR_PENDING = 2'd0;
    localparam logic [1:0] ADR_MASK    = 2'd1;
    localparam logic [1:0] ADR_VECTOR  = 2'd2;
    localparam logic [1:0] ADR_MODE    = 2'd3;

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] irq_q;

    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] mask_next;
    logic [N_SRC-1:0] mode_next;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] int_src;
    logic [N_SRC-1:0] active;
    logic             accept;
    logic             wr;
    logic [1:0]       sel;
    logic [4:0]       lowest;
    logic [31:0]      vector;
    logic [31:0]      rd_data;

    logic unused_bits;
    assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[31:N_SRC]};

    always_comb begin
        accept    = cs_i & ~ack_o;
        wr        = accept & we_i;
        sel       = adr_i[3:2];
        mask_next = (wr && sel == ADR_MASK) ? dat_i[N_SRC-1:0] : mask;
        mode_next = (wr && sel == ADR_MODE) ? dat_i[N_SRC-1:0] : mode;
        w1c       = (wr && sel == ADR_PENDING) ? dat_i[N_SRC-1:0] : '0;
        pending_next = '0;
        // A new edge beats a simultaneous W1C; level sources just mirror the line.
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_next[i])
                pending_next[i] = (irq_i[i] & ~irq_q[i]) | (pending[i] & ~w1c[i]);
            else
                pending_next[i] = irq_i[i];
        end
        // Level sources request from the registered line, giving them one extra cycle.
        int_src = (mode_next & pending_next) | (~mode_next & pending);
    end

    always_comb begin
        active = pending & mask;
        lowest = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i])
                lowest = 5'(i);
        end
        vector = {|active, 26'd0, lowest};
        case (sel)
            ADR_PENDING: rd_data = 32'(pending);
            ADR_MASK:    rd_data = 32'(mask);
            ADR_VECTOR:  rd_data = vector;
            default:     rd_data = 32'(mode);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending <= '0;
            mask    <= '1;
            mode    <= '0;
            irq_q   <= '0;
            ack_o   <= 1'b0;
            dat_o   <= 32'd0;
            int_o   <= 1'b0;
        end else begin
            irq_q   <= irq_i;
            pending <= pending_next;
            mask    <= mask_next;
            mode    <= mode_next;
            int_o   <= |(int_src & mask_next);
            ack_o   <= accept;
            if (accept && !we_i)
                dat_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard testbench for irq_controller: bus reads queue expected data, a monitor
// compares it when ack_o appears; interrupt output is checked at fixed cycle offsets.
module tb_irq_controller;

    localparam int N_SRC = 8;
    localparam logic [31:0] A_PENDING = 32'h0;
    localparam logic [31:0] A_MASK    = 32'h4;
    localparam logic [31:0] A_VECTOR  = 32'h8;
    localparam logic [31:0] A_MODE    = 32'hC;

    logic             clk = 1'b0;
    logic             rst;
    logic             cs;
    logic             we;
    logic [31:0]      adr;
    logic [31:0]      datIn;
    logic [31:0]      datOut;
    logic             ack;
    logic [N_SRC-1:0] irqIn;
    logic             intOut;

    typedef struct {
        string       tag;
        logic [31:0] expVal;
        bit          isRead;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    int assertCount = 0;
    int failCount   = 0;
    int ackCount    = 0;

    irq_controller #(.N_SRC(N_SRC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cs_i  (cs),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (datIn),
        .dat_o (datOut),
        .ack_o (ack),
        .irq_i (irqIn),
        .int_o (intOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Every ack must match the oldest queued access; reads also compare dat_o.
    always @(negedge clk) begin : monitor
        sbEntry_t e;
        if (ack === 1'b1) begin
            ackCount++;
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sbQueue.pop_front();
                if (e.isRead)
                    checkOutput(e.tag, datOut, e.expVal);
            end
        end
    end

    task automatic pushExpect(input string tag, input logic [31:0] value, input bit isRead);
        sbEntry_t e;
        e.tag    = tag;
        e.expVal = value;
        e.isRead = isRead;
        sbQueue.push_back(e);
    endtask

    task automatic busRead(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        @(negedge clk);
        cs  = 1'b1;
        we  = 1'b0;
        adr = addr;
        pushExpect(tag, expected, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_ack"}, 32'(ack), 32'd1);
        cs = 1'b0;
    endtask

    task automatic busWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cs    = 1'b1;
        we    = 1'b1;
        adr   = addr;
        datIn = data;
        pushExpect(tag, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_ack"}, 32'(ack), 32'd1);
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic applyStimulus(input logic [N_SRC-1:0] value);
        @(negedge clk);
        irqIn = value;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: actual timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin : stimulus
        int startAck;
        rst   = 1'b1;
        cs    = 1'b0;
        we    = 1'b0;
        adr   = 32'd0;
        datIn = 32'd0;
        irqIn = '0;
        waitCycles(3);
        checkOutput("rst_int", 32'(intOut), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_dat", datOut, 32'd0);
        rst = 1'b0;
        busRead("rst_mask", A_MASK, 32'h0000_00FF);
        busRead("rst_mode", A_MODE, 32'h0000_0000);
        busRead("rst_pending", A_PENDING, 32'h0000_0000);

        $display("[TB] level source after reset");
        applyStimulus(8'h04);
        @(negedge clk);
        checkOutput("t1_int_edge1", 32'(intOut), 32'd0);
        @(negedge clk);
        checkOutput("t1_int_edge2", 32'(intOut), 32'd1);
        busRead("t1_vector", A_VECTOR, 32'h8000_0002);
        applyStimulus(8'h00);
        waitCycles(2);
        checkOutput("t1_int_drop", 32'(intOut), 32'd0);

        $display("[TB] edge pulse and W1C");
        busWrite("t2_mode", A_MODE, 32'h0000_00FF);
        applyStimulus(8'h02);
        @(negedge clk);
        checkOutput("t2_int_set", 32'(intOut), 32'd1);
        irqIn = 8'h00;
        waitCycles(2);
        checkOutput("t2_int_hold", 32'(intOut), 32'd1);
        busRead("t2_pending", A_PENDING, 32'h0000_0002);
        busWrite("t2_w1c", A_PENDING, 32'h0000_0002);
        checkOutput("t2_int_clear", 32'(intOut), 32'd0);

        $display("[TB] masked latching");
        busWrite("t3_mask_off", A_MASK, 32'h0000_0000);
        applyStimulus(8'h20);
        @(negedge clk);
        irqIn = 8'h00;
        checkOutput("t3_int_masked", 32'(intOut), 32'd0);
        busRead("t3_pending", A_PENDING, 32'h0000_0020);
        busWrite("t3_mask_on", A_MASK, 32'h0000_0020);
        checkOutput("t3_int_unmask", 32'(intOut), 32'd1);
        busWrite("t3_w1c", A_PENDING, 32'h0000_0020);
        checkOutput("t3_int_clear", 32'(intOut), 32'd0);
        busWrite("t3_mask_all", A_MASK, 32'h0000_00FF);

        $display("[TB] set beats W1C");
        applyStimulus(8'h08);
        @(negedge clk);
        irqIn = 8'h00;
        checkOutput("t4_int_pre", 32'(intOut), 32'd1);
        @(negedge clk);
        irqIn = 8'h08;
        cs    = 1'b1;
        we    = 1'b1;
        adr   = A_PENDING;
        datIn = 32'h0000_0008;
        pushExpect("t4_w1c", 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("t4_w1c_ack", 32'(ack), 32'd1);
        checkOutput("t4_int_kept", 32'(intOut), 32'd1);
        cs = 1'b0;
        we = 1'b0;
        busRead("t4_pending", A_PENDING, 32'h0000_0008);
        applyStimulus(8'h00);
        busWrite("t4_cleanup", A_PENDING, 32'h0000_0008);
        checkOutput("t4_int_clear", 32'(intOut), 32'd0);

        $display("[TB] vector priority");
        applyStimulus(8'h09);
        @(negedge clk);
        irqIn = 8'h00;
        busRead("t5_vector0", A_VECTOR, 32'h8000_0000);
        busWrite("t5_w1c0", A_PENDING, 32'h0000_0001);
        busRead("t5_vector3", A_VECTOR, 32'h8000_0003);
        busWrite("t5_w1c3", A_PENDING, 32'h0000_0008);
        checkOutput("t5_int_clear", 32'(intOut), 32'd0);
        busRead("t5_vector_none", A_VECTOR, 32'h0000_0000);

        $display("[TB] back-to-back reads and reset during ack");
        busWrite("t6_mode", A_MODE, 32'h0000_0000);
        @(negedge clk);
        cs  = 1'b1;
        we  = 1'b0;
        adr = A_MASK;
        for (int i = 0; i < 3; i++)
            pushExpect("t6_mask_read", 32'h0000_00FF, 1'b1);
        startAck = ackCount;
        waitCycles(6);
        cs = 1'b0;
        checkOutput("t6_ack_pulses", 32'(ackCount - startAck), 32'd3);
        applyStimulus(8'h10);
        waitCycles(2);
        checkOutput("t6_int_level", 32'(intOut), 32'd1);
        @(negedge clk);
        cs  = 1'b1;
        we  = 1'b0;
        adr = A_VECTOR;
        @(posedge clk);
        #2;
        checkOutput("t6_ack_pre_rst", 32'(ack), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_ack_rst", 32'(ack), 32'd0);
        checkOutput("t6_int_rst", 32'(intOut), 32'd0);
        cs    = 1'b0;
        irqIn = 8'h00;
        waitCycles(2);
        rst = 1'b0;
        busRead("t6_mask_after", A_MASK, 32'h0000_00FF);
        busRead("t6_mode_after", A_MODE, 32'h0000_0000);

        waitCycles(2);
        checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
